// File: rtl/dmux8way16_dispatcher_pkg.sv
// Shared dispatch definitions: FSM encodings, sink count and the sink-select decode.
package dmux8way16_dispatcher_pkg;

  localparam int NSINK = 8;
  localparam int SELW  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NSINK-1:0] onehot8(input logic [SELW-1:0] sel);
    logic [NSINK-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dmux8way16_dispatcher_dmux.sv
// 1-to-8 data demux: the selected bus carries the input word, every other bus is zero.
// Purely combinational, no flow control of its own.
module dmux8way16_dispatcher_dmux #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h
);

  always_comb begin
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    e = '0;
    f = '0;
    g = '0;
    h = '0;
    case (sel)
      3'd0: a = in;
      3'd1: b = in;
      3'd2: c = in;
      3'd3: d = in;
      3'd4: e = in;
      3'd5: f = in;
      3'd6: g = in;
      default: h = in;
    endcase
  end

endmodule

// File: rtl/dmux8way16_dispatcher.sv
// One-word skid dispatcher: steers each accepted word to a directed or round-robin sink; word visible the cycle after accept.
// Holds the word until its own sink's ready; in_ready follows that single ready bit so full throughput is one word per cycle.
module dmux8way16_dispatcher
  import dmux8way16_dispatcher_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [2:0]       in_sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [7:0]       xfer_count
);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       dest;
  logic [2:0]       rr_ptr;
  logic [2:0]       sel_nxt;
  logic [WIDTH-1:0] held;
  logic             xfer;
  logic             accept;

  assign xfer    = (state == HOLD) && out_ready[dest];
  assign accept  = in_valid && in_ready;
  assign sel_nxt = mode ? rr_ptr : in_sel;

  // Only the ready bit of the held word's sink matters; the rest are ignored.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = (state == IDLE) ? 1'b1 : out_ready[dest];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (xfer && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The held word is cleared on drain so an idle dispatcher shows zero on every bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dest       <= '0;
      rr_ptr     <= '0;
      held       <= '0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        held <= in_data;
        dest <= sel_nxt;
      end else if (xfer) begin
        held <= '0;
      end
      if (accept && mode) rr_ptr <= rr_ptr + 3'd1;
      if (xfer) xfer_count <= xfer_count + 8'd1;
    end
  end

  assign out_valid = (state == HOLD) ? onehot8(dest) : '0;

  dmux8way16_dispatcher_dmux #(.WIDTH(WIDTH)) u_dmux (
    .in  (held),
    .sel (dest),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h)
  );

endmodule

// File: tb/tb_dmux8way16_dispatcher.sv
// Scoreboard bench for dmux8way16_dispatcher: expected (sink, word) pairs queued at accept, compared at transfer.
module tb_dmux8way16_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [2:0]  in_sel;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [7:0]  xfer_count;

  logic [15:0] bus [8];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_dat_q [$];
  int          exp_sink_q [$];
  logic [7:0]  exp_count = 8'd0;
  logic [2:0]  exp_rr = 3'd0;

  dmux8way16_dispatcher #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .in_sel     (in_sel),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus[0] = a; bus[1] = b; bus[2] = c; bus[3] = d;
    bus[4] = e; bus[5] = f; bus[6] = g; bus[7] = h;
  end

  function automatic int onehot_idx(input logic [7:0] v);
    int idx = -1;
    int n = 0;
    for (int k = 0; k < 8; k++) begin
      if (v[k] === 1'b1) begin
        idx = k;
        n++;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic sb_push(input logic [15:0] dat, input int sink);
    exp_dat_q.push_back(dat);
    exp_sink_q.push_back(sink);
  endtask

  // Pops the oldest expectation and captures what the DUT presents; comparison is left to the caller.
  task automatic sb_pop_obs(output int exp_s, output logic [15:0] exp_d,
                            output int obs_s, output logic [15:0] obs_d);
    obs_s = onehot_idx(out_valid);
    obs_d = (obs_s >= 0) ? bus[obs_s[2:0]] : 16'hxxxx;
    if (exp_sink_q.size() == 0) begin
      exp_s = -2;
      exp_d = 16'hxxxx;
    end else begin
      exp_s = exp_sink_q.pop_front();
      exp_d = exp_dat_q.pop_front();
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({in_ready, out_valid, xfer_count} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%h xfer_count=%0d, expected 0/00/0", in_ready, out_valid, xfer_count);
    end
    n_checks++;
    if ({a, b, c, d, e, f, g, h} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_buses: %h, expected all zero", {a, b, c, d, e, f, g, h});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed;
    int es, os;
    logic [15:0] ed, od;
    @(negedge clk);
    mode = 1'b0; in_sel = 3'd6; in_data = 16'h0658; in_valid = 1'b1; out_ready = 8'hFF;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_in_ready_idle: got %b, expected 1", in_ready);
    end
    sb_push(16'h0658, 6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (g !== 16'h0658 || out_valid !== 8'b0100_0000) begin
      n_fail++;
      $display("FAIL dir_out: g=%h out_valid=%b, expected 0658 01000000", g, out_valid);
    end
    n_checks++;
    if ({a, b, c, d, e, f, h} !== 112'd0) begin
      n_fail++;
      $display("FAIL dir_others_zero: %h, expected zero", {a, b, c, d, e, f, h});
    end
    sb_pop_obs(es, ed, os, od);
    exp_count++;
    n_checks++;
    if (os != es || od !== ed) begin
      n_fail++;
      $display("FAIL dir_xfer: sink %0d word %h, expected sink %0d word %h", os, od, es, ed);
    end
    @(posedge clk); #1;
    n_checks++;
    if (xfer_count !== exp_count || out_valid !== 8'd0) begin
      n_fail++;
      $display("FAIL dir_count: xfer_count=%0d out_valid=%h, expected %0d 00", xfer_count, out_valid, exp_count);
    end
  endtask

  task automatic test_backpressure;
    int es, os;
    logic [15:0] ed, od;
    @(negedge clk);
    mode = 1'b0; in_sel = 3'd5; in_data = 16'hABCD; in_valid = 1'b1; out_ready = 8'h00;
    sb_push(16'hABCD, 5);
    @(posedge clk); #1;
    in_data = 16'hDEAD; in_sel = 3'd1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({f, out_valid, in_ready, xfer_count} !== {16'hABCD, 8'h20, 1'b0, exp_count}) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: f=%h out_valid=%h in_ready=%b count=%0d, expected abcd 20 0 %0d",
                 i, f, out_valid, in_ready, xfer_count, exp_count);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 8'h20;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b, expected 1", in_ready);
    end
    sb_pop_obs(es, ed, os, od);
    exp_count++;
    n_checks++;
    if (os != es || od !== ed) begin
      n_fail++;
      $display("FAIL bp_xfer: sink %0d word %h, expected sink %0d word %h", os, od, es, ed);
    end
    @(posedge clk); #1;
    n_checks++;
    if (xfer_count !== exp_count || out_valid !== 8'd0) begin
      n_fail++;
      $display("FAIL bp_count: xfer_count=%0d out_valid=%h, expected %0d 00", xfer_count, out_valid, exp_count);
    end
  endtask

  task automatic test_ignored_ready;
    int es, os;
    logic [15:0] ed, od;
    @(negedge clk);
    mode = 1'b0; in_sel = 3'd2; in_data = 16'h5A5A; in_valid = 1'b1; out_ready = 8'b1111_1011;
    sb_push(16'h5A5A, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({c, out_valid, in_ready, xfer_count} !== {16'h5A5A, 8'h04, 1'b0, exp_count}) begin
        n_fail++;
        $display("FAIL ign_stall[%0d]: c=%h out_valid=%h in_ready=%b count=%0d, expected 5a5a 04 0 %0d",
                 i, c, out_valid, in_ready, xfer_count, exp_count);
      end
      @(posedge clk); #1;
    end
    out_ready = 8'hFF;
    #1;
    sb_pop_obs(es, ed, os, od);
    exp_count++;
    n_checks++;
    if (os != es || od !== ed) begin
      n_fail++;
      $display("FAIL ign_xfer: sink %0d word %h, expected sink %0d word %h", os, od, es, ed);
    end
    @(posedge clk); #1;
    n_checks++;
    if (xfer_count !== exp_count) begin
      n_fail++;
      $display("FAIL ign_count: xfer_count=%0d, expected %0d", xfer_count, exp_count);
    end
  endtask

  task automatic test_back_to_back_rr;
    int es, os;
    logic [15:0] ed, od;
    mode = 1'b1;
    out_ready = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      in_data = 16'(i + 1);
      in_valid = 1'b1;
      in_sel = 3'd7;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_in_ready[%0d]: got %b, expected 1", i, in_ready);
      end
      if (i > 0) begin
        sb_pop_obs(es, ed, os, od);
        exp_count++;
        n_checks++;
        if (os != es || od !== ed) begin
          n_fail++;
          $display("FAIL rr_xfer[%0d]: sink %0d word %h, expected sink %0d word %h", i, os, od, es, ed);
        end
      end
      sb_push(16'(i + 1), int'(exp_rr));
      exp_rr = exp_rr + 3'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    sb_pop_obs(es, ed, os, od);
    exp_count++;
    n_checks++;
    if (os != es || od !== ed) begin
      n_fail++;
      $display("FAIL rr_xfer_last: sink %0d word %h, expected sink %0d word %h", os, od, es, ed);
    end
    @(posedge clk); #1;
    n_checks++;
    if (xfer_count !== exp_count || out_valid !== 8'd0) begin
      n_fail++;
      $display("FAIL rr_count: xfer_count=%0d out_valid=%h, expected %0d 00", xfer_count, out_valid, exp_count);
    end
  endtask

  task automatic test_reset_mid_hold;
    @(negedge clk);
    mode = 1'b0; in_sel = 3'd3; in_data = 16'h1234; in_valid = 1'b1; out_ready = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (d !== 16'h1234 || out_valid !== 8'h08) begin
      n_fail++;
      $display("FAIL rst_hold_setup: d=%h out_valid=%h, expected 1234 08", d, out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    exp_count = 8'd0;
    exp_rr = 3'd0;
    n_checks++;
    if ({out_valid, xfer_count, in_ready} !== 17'd0 || {a, b, c, d, e, f, g, h} !== 128'd0) begin
      n_fail++;
      $display("FAIL rst_async: out_valid=%h count=%0d in_ready=%b buses=%h, expected all zero",
               out_valid, xfer_count, in_ready, {a, b, c, d, e, f, g, h});
    end
    out_ready = 8'hFF;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 8'd0 || xfer_count !== exp_count) begin
      n_fail++;
      $display("FAIL rst_no_xfer: out_valid=%h count=%0d, expected 00 0", out_valid, xfer_count);
    end
  endtask

  task automatic test_counter_wrap;
    int es, os;
    logic [15:0] ed, od;
    @(negedge clk);
    reset = 1'b0;
    mode = 1'b1; in_data = 16'h7000; in_sel = 3'd5; in_valid = 1'b1; out_ready = 8'hFF;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_first_accept: in_ready=%b, expected 1", in_ready);
    end
    sb_push(16'h7000, int'(exp_rr));
    exp_rr = exp_rr + 3'd1;
    @(posedge clk); #1;
    mode = 1'b0;
    for (int i = 1; i < 256; i++) begin
      in_data = 16'h7000 + 16'(i);
      in_sel = 3'(i);
      #1;
      sb_pop_obs(es, ed, os, od);
      exp_count++;
      n_checks++;
      if (os != es || od !== ed) begin
        n_fail++;
        $display("FAIL wrap_xfer[%0d]: sink %0d word %h, expected sink %0d word %h", i, os, od, es, ed);
      end
      sb_push(16'h7000 + 16'(i), i % 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    sb_pop_obs(es, ed, os, od);
    exp_count++;
    n_checks++;
    if (os != es || od !== ed) begin
      n_fail++;
      $display("FAIL wrap_xfer_last: sink %0d word %h, expected sink %0d word %h", os, od, es, ed);
    end
    @(posedge clk); #1;
    n_checks++;
    if (xfer_count !== exp_count || xfer_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_count: xfer_count=%0d, expected %0d", xfer_count, exp_count);
    end
    n_checks++;
    if (exp_sink_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d words outstanding, expected 0", exp_sink_q.size());
    end
  endtask

  initial begin
    in_data = 16'd0;
    in_valid = 1'b0;
    mode = 1'b0;
    in_sel = 3'd0;
    out_ready = 8'd0;
    test_reset();
    test_directed();
    test_backpressure();
    test_ignored_ready();
    test_back_to_back_rr();
    test_reset_mid_hold();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
